// File: rtl/keyboard_decoder.sv
// PS/2 keyboard front end: synchronises the raw lines, receives 11-bit frames and filters make codes into
// 3-bit game operations, which are offered over a ready/read_fin handshake with one pending slot behind it.
module keyboard_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int LOG2_TIMEOUT   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ps2_clock,
  input  logic       ps2_data,
  input  logic       keyboard_read_fin,
  output logic       keyboard_ready,
  output logic [2:0] keyboard_data,
  output logic       frame_error_o,
  output logic       dropped_o
);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {H_IDLE, H_VALID, H_WAIT} hs_state_t;

  localparam logic [2:0] OP_W     = 3'b000;
  localparam logic [2:0] OP_A     = 3'b001;
  localparam logic [2:0] OP_S     = 3'b010;
  localparam logic [2:0] OP_D     = 3'b011;
  localparam logic [2:0] OP_SPACE = 3'b100;
  localparam logic [2:0] OP_Z     = 3'b101;
  localparam logic [2:0] OP_NONE  = 3'b110;
  localparam logic [7:0] BREAK_CODE    = 8'hF0;
  localparam logic [7:0] EXTENDED_CODE = 8'hE0;
  localparam logic [LOG2_TIMEOUT-1:0] TIMEOUT_LAST = LOG2_TIMEOUT'(TIMEOUT_CYCLES - 1);

  // Odd parity holds when the data bits plus the parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

  logic [SYNC_STAGES-1:0]  ps2_clock_sync_r;
  logic [SYNC_STAGES-1:0]  ps2_data_sync_r;
  logic                    ps2_clock_prev_r;
  logic                    ps2_clock_s;
  logic                    ps2_data_s;
  logic                    falling_edge_s;

  rx_state_t               rx_state_r;
  logic [2:0]              bit_cnt_r;
  logic [7:0]              shift_r;
  logic                    parity_r;
  logic [LOG2_TIMEOUT-1:0] timeout_cnt_r;
  logic                    byte_valid_r;
  logic [7:0]              byte_r;
  logic                    flag_clear_r;

  logic                    break_r;
  logic                    extended_r;
  logic                    op_valid_s;
  logic [2:0]              op_code_s;

  hs_state_t               hs_state_r;
  logic                    pend_valid_r;
  logic [2:0]              pend_data_r;

  assign ps2_clock_s    = ps2_clock_sync_r[SYNC_STAGES-1];
  assign ps2_data_s     = ps2_data_sync_r[SYNC_STAGES-1];
  assign falling_edge_s = ps2_clock_prev_r & ~ps2_clock_s;

  // Bring both PS/2 lines into the clock domain; idle lines are high.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ps2_clock_sync_r <= {SYNC_STAGES{1'b1}};
      ps2_data_sync_r  <= {SYNC_STAGES{1'b1}};
      ps2_clock_prev_r <= 1'b1;
    end else begin
      ps2_clock_sync_r <= {ps2_clock_sync_r[SYNC_STAGES-2:0], ps2_clock};
      ps2_data_sync_r  <= {ps2_data_sync_r[SYNC_STAGES-2:0], ps2_data};
      ps2_clock_prev_r <= ps2_clock_s;
    end
  end

  // Frame receiver: start, 8 data bits LSB first, parity, stop, with a mid-frame idle timeout.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state_r    <= RX_IDLE;
      bit_cnt_r     <= 3'd0;
      shift_r       <= 8'h00;
      parity_r      <= 1'b0;
      timeout_cnt_r <= '0;
      byte_valid_r  <= 1'b0;
      byte_r        <= 8'h00;
      frame_error_o <= 1'b0;
      flag_clear_r  <= 1'b0;
    end else begin
      byte_valid_r  <= 1'b0;
      frame_error_o <= 1'b0;
      flag_clear_r  <= 1'b0;
      if (falling_edge_s) begin
        timeout_cnt_r <= '0;
        case (rx_state_r)
          RX_IDLE: begin
            if (!ps2_data_s) begin
              rx_state_r <= RX_DATA;
              bit_cnt_r  <= 3'd0;
            end else begin
              frame_error_o <= 1'b1;
            end
          end
          RX_DATA: begin
            shift_r <= {ps2_data_s, shift_r[7:1]};
            if (bit_cnt_r == 3'd7) begin
              rx_state_r <= RX_PARITY;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
          RX_PARITY: begin
            parity_r   <= ps2_data_s;
            rx_state_r <= RX_STOP;
          end
          RX_STOP: begin
            if (ps2_data_s && odd_parity_ok(shift_r, parity_r)) begin
              byte_valid_r <= 1'b1;
              byte_r       <= shift_r;
            end else begin
              frame_error_o <= 1'b1;
              flag_clear_r  <= 1'b1;
            end
            rx_state_r <= RX_IDLE;
          end
          default: rx_state_r <= RX_IDLE;
        endcase
      end else if (rx_state_r != RX_IDLE) begin
        if (timeout_cnt_r == TIMEOUT_LAST) begin
          frame_error_o <= 1'b1;
          rx_state_r    <= RX_IDLE;
          timeout_cnt_r <= '0;
        end else begin
          timeout_cnt_r <= timeout_cnt_r + LOG2_TIMEOUT'(1);
        end
      end
    end
  end

  // Translate a received byte into an operation; prefixed bytes and unmapped codes yield nothing.
  always_comb begin
    op_valid_s = 1'b0;
    op_code_s  = OP_NONE;
    if (byte_valid_r && byte_r != BREAK_CODE && byte_r != EXTENDED_CODE && !break_r && !extended_r) begin
      op_valid_s = 1'b1;
      case (byte_r)
        8'h1D:   op_code_s = OP_W;
        8'h1C:   op_code_s = OP_A;
        8'h1B:   op_code_s = OP_S;
        8'h23:   op_code_s = OP_D;
        8'h29:   op_code_s = OP_SPACE;
        8'h1A:   op_code_s = OP_Z;
        default: begin
          op_valid_s = 1'b0;
          op_code_s  = OP_NONE;
        end
      endcase
    end else begin
      op_valid_s = 1'b0;
      op_code_s  = OP_NONE;
    end
  end

  // Break/extended prefix flags apply to exactly the next byte; a corrupt frame also cancels them.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      break_r    <= 1'b0;
      extended_r <= 1'b0;
    end else if (flag_clear_r) begin
      break_r    <= 1'b0;
      extended_r <= 1'b0;
    end else if (byte_valid_r) begin
      if (byte_r == BREAK_CODE) begin
        break_r <= 1'b1;
      end else if (byte_r == EXTENDED_CODE) begin
        extended_r <= 1'b1;
      end else begin
        break_r    <= 1'b0;
        extended_r <= 1'b0;
      end
    end else begin
      break_r    <= break_r;
      extended_r <= extended_r;
    end
  end

  // Producer side of the handshake with a single pending slot; the oldest operation always wins.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hs_state_r     <= H_IDLE;
      keyboard_ready <= 1'b0;
      keyboard_data  <= OP_NONE;
      pend_valid_r   <= 1'b0;
      pend_data_r    <= OP_NONE;
      dropped_o      <= 1'b0;
    end else begin
      dropped_o <= 1'b0;
      case (hs_state_r)
        H_IDLE: begin
          if (pend_valid_r) begin
            keyboard_data  <= pend_data_r;
            keyboard_ready <= 1'b1;
            hs_state_r     <= H_VALID;
            if (op_valid_s) begin
              pend_data_r <= op_code_s;
            end else begin
              pend_valid_r <= 1'b0;
            end
          end else if (op_valid_s) begin
            keyboard_data  <= op_code_s;
            keyboard_ready <= 1'b1;
            hs_state_r     <= H_VALID;
          end else begin
            keyboard_ready <= 1'b0;
          end
        end
        H_VALID, H_WAIT: begin
          if (op_valid_s) begin
            if (!pend_valid_r) begin
              pend_valid_r <= 1'b1;
              pend_data_r  <= op_code_s;
            end else begin
              dropped_o <= 1'b1;
            end
          end
          if (hs_state_r == H_VALID) begin
            if (keyboard_read_fin) begin
              keyboard_ready <= 1'b0;
              hs_state_r     <= H_WAIT;
            end
          end else if (!keyboard_read_fin) begin
            hs_state_r <= H_IDLE;
          end
        end
        default: begin
          hs_state_r     <= H_IDLE;
          keyboard_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/keyboard_decoder.md
Name: keyboard_decoder

Overview:
- Converts the raw PS/2 keyboard stream into 3-bit game operations.
- Delivers each operation to the game logic block over the keyboard_ready / keyboard_data / keyboard_read_fin handshake; this block is the producer side and the game logic is the consumer.
- Only key make codes are forwarded. Break codes, extended codes, unmapped codes and corrupt frames are filtered out.
- Holds one pending operation so that a key arriving during a handshake is not lost.

Parameters:
- SYNC_STAGES, 2: flip-flop depth of the synchronizer on ps2_clock and on ps2_data.
- TIMEOUT_CYCLES, 50000: idle system-clock cycles in mid-frame after which the partial frame is abandoned.
- LOG2_TIMEOUT, 16: width of the timeout counter.

Ports:
- clock, in, 1: system clock; all logic is on its rising edge.
- reset, in, 1: asynchronous, active-low reset.
- ps2_clock, in, 1: raw PS/2 clock from the keyboard, asynchronous to clock.
- ps2_data, in, 1: raw PS/2 data from the keyboard, asynchronous to clock.
- keyboard_read_fin, in, 1: consumer acknowledge; high means the presented data has been read.
- keyboard_ready, out, 1: keyboard_data holds a valid, not yet acknowledged operation.
- keyboard_data, out, 3: operation code. W=000, A=001, S=010, D=011, SPACE=100, Z=101, NONE=110.
- frame_error_o, out, 1: one-cycle pulse on a parity error, a bad start or stop bit, or a timeout.
- dropped_o, out, 1: one-cycle pulse when a decoded operation is discarded because the pending slot is full.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - keyboard_ready=0, keyboard_data=110, frame_error_o=0, dropped_o=0;
  - frame receiver to IDLE, bit counter 0, break flag 0, extended flag 0;
  - pending slot empty, handshake FSM to H_IDLE.
- Reset asserted mid-frame or mid-handshake discards everything; no partial state survives.
- Synchronizer and edge detect: both PS/2 lines pass through SYNC_STAGES flip-flops. A falling edge is synchronized ps2_clock going 1→0 between consecutive cycles. Data is sampled on that cycle.
- Frame receiver states:
  - IDLE: on a falling edge with data=0 (start bit), go to DATA. A falling edge with data=1 pulses frame_error_o and stays in IDLE.
  - DATA: shift 8 bits LSB first, then go to PARITY.
  - PARITY: capture the bit, then go to STOP.
  - STOP: require data=1 and odd parity over the 8 data bits plus the parity bit. Pass → byte valid for one cycle. Fail → pulse frame_error_o and clear the break and extended flags. Return to IDLE either way.
- Timeout: in any state other than IDLE, the counter increments every cycle without a falling edge and clears on each falling edge. Reaching TIMEOUT_CYCLES pulses frame_error_o and returns to IDLE.
- Byte interpretation:
  - 0xF0 sets the break flag.
  - 0xE0 sets the extended flag.
  - Any other byte: if either flag is set, clear both and emit nothing.
  - Otherwise map 0x1D→W, 0x1C→A, 0x1B→S, 0x23→D, 0x29→SPACE, 0x1A→Z. Unmapped bytes emit nothing.
- Handshake FSM states:
  - H_IDLE: keyboard_ready=0. A new operation, or a non-empty pending slot, loads keyboard_data and sets keyboard_ready=1 on the next edge. The pending slot has priority over a same-cycle new operation; the new one goes to the pending slot.
  - H_VALID: keyboard_ready=1 and keyboard_data is stable. When keyboard_read_fin=1 is sampled, clear keyboard_ready on that edge and go to H_WAIT.
  - H_WAIT: keyboard_ready=0. Stay until keyboard_read_fin=0 is sampled, then go to H_IDLE. This guarantees the consumer sees ready low before the next operation is offered.
- keyboard_data keeps its last value after ready falls. It is never changed while keyboard_ready=1.
- Pending slot: depth 1. An operation decoded in H_VALID or H_WAIT goes into the slot if it is empty. If the slot is full, dropped_o pulses and the new operation is discarded, so the oldest operation wins.
- Latency: keyboard_ready rises no more than SYNC_STAGES+3 cycles after the raw falling edge of the stop bit, when the FSM is in H_IDLE with an empty slot.

Test Plan:
- Clean frame for byte 0x1D (odd parity bit 1), PS/2 clock period 2000 cycles, consumer raises fin 1 cycle after ready → keyboard_data=000, keyboard_ready=1 within 5 cycles of the stop edge; ready drops the cycle after fin is sampled.
- Sequence 0x29, then 0xF0, 0x29 → exactly one SPACE (100) delivered; the break-prefixed 0x29 produces no ready.
- Frame 0x1C with the parity bit inverted → frame_error_o single pulse, no ready, keyboard_data stays 110 after reset; following valid 0x23 → D (011).
- Three keys W, S, Z sent while the consumer holds fin=0 → W presented, S pending, Z causes a dropped_o pulse; releasing the handshake yields W then S only.
- Start bit followed by 3 data bits, then lines idle for 50000 cycles → frame_error_o pulse at the timeout; next full 0x1A frame → Z (101).
- reset=0 asserted for one cycle in H_VALID with the pending slot full → ready=0, data=110 immediately; no stale operation appears after reset is released.
